// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types and constants for the configurable SPI master
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Cycles from the cycle start is sampled in to the done cycle
    function automatic int unsigned frame_cycles(input int unsigned data_w, input int unsigned clk_div);
        return 1 + clk_div * (2 * data_w + 2);
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - SCLK half-period divider with leading/trailing phase flag
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic phase_en,
    output logic tick,
    output logic trail
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // Divider counts 0..CLK_DIV-1; phase flips on each SCLK edge while phase_en is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            trail <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            trail <= 1'b0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick && phase_en) begin
                trail <= ~trail;
            end
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable SPI master (optional SPI_MASTER_LOOPBACK_EN adds loopback input)
module spi_master_cfg
    import spi_cfg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    spi_state_t        state, state_next;
    logic              tick, trail;
    logic              mode_cpol, mode_cpha;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic              rx_in;
    logic              accept, last_edge, finish;
    logic              xfer_tick, lead_tick, trail_tick, do_sample, do_shift;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        if (LSB_FIRST != 0) begin
            return {b, v[DATA_W-1:1]};
        end
        return {v[DATA_W-2:0], b};
    endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_in = loopback ? mosi : miso;
`else
    assign rx_in = miso;
`endif

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (reset_n),
        .en       (state != IDLE),
        .clr      (state == IDLE),
        .phase_en (state == XFER),
        .tick     (tick),
        .trail    (trail)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-edge strobes; sample/shift roles swap with cpha
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_edge  = 1'b0;
        finish     = 1'b0;
        xfer_tick  = (state == XFER) && tick;
        lead_tick  = xfer_tick && !trail;
        trail_tick = xfer_tick && trail;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    accept     = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (trail_tick && (bit_cnt == BIT_LAST)) begin
                    state_next = HOLD;
                    last_edge  = 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        do_sample = mode_cpha ? trail_tick : lead_tick;
        do_shift  = mode_cpha ? lead_tick : (trail_tick && !last_edge);
    end

    // Pin flops, mode latches and shift registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            mode_cpol <= 1'b0;
            mode_cpha <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                mode_cpol <= cpol;
                mode_cpha <= cpha;
                sclk      <= cpol;
                cs_n      <= 1'b0;
                busy      <= 1'b1;
                bit_cnt   <= '0;
                if (!cpha) begin
                    mosi  <= first_bit(tx_data);
                    tx_sr <= shift_out(tx_data);
                end else begin
                    tx_sr <= tx_data;
                end
            end
            if (xfer_tick) begin
                sclk <= ~sclk;
            end
            if (do_shift) begin
                mosi  <= first_bit(tx_sr);
                tx_sr <= shift_out(tx_sr);
            end
            if (do_sample) begin
                rx_sr <= shift_in(rx_sr, rx_in);
            end
            if (trail_tick) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (finish) begin
                cs_n    <= 1'b1;
                busy    <= 1'b0;
                rx_data <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - scoreboard bench for spi_master_cfg (8-bit MSB-first and 16-bit LSB-first instances)
module tb_spi_master_cfg;
    import spi_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic        miso = 1'b0;
    logic [7:0]  tx0 = '0;
    logic [15:0] tx1 = '0;
    logic        busy0, done0, sclk0, mosi0, cs_n0;
    logic        busy1, done1, sclk1, mosi1, cs_n1;
    logic [7:0]  rx0;
    logic [15:0] rx1;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(4), .LSB_FIRST(0)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .cpol(cpol), .cpha(cpha),
        .tx_data(tx0), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .busy(busy0), .done(done0), .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(4), .LSB_FIRST(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .cpol(cpol), .cpha(cpha),
        .tx_data(tx1), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] rx;
        logic [31:0] sl;
        int          lat;
        int          t0;
        int          w;
        logic        cpol;
    } exp_t;
    exp_t sbq[$];

    // Slave model, serving whichever instance is selected
    int          sel = 0;
    logic        sl_cpol = 1'b0, sl_cpha = 1'b0, sl_lsb = 1'b0, sl_quiet = 1'b0;
    int          sl_w = 8;
    int          sl_idx = 0;
    logic [31:0] sl_reply = '0, sl_cap = '0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;
    logic        s_sclk, s_mosi, s_cs;
    assign s_sclk = (sel != 0) ? sclk1 : sclk0;
    assign s_mosi = (sel != 0) ? mosi1 : mosi0;
    assign s_cs   = (sel != 0) ? cs_n1 : cs_n0;

    task automatic slave_drive();
        if (sl_quiet || sl_idx >= sl_w) miso = 1'b0;
        else miso = sl_reply[sl_lsb ? sl_idx : (sl_w - 1 - sl_idx)];
        sl_idx++;
    endtask

    always @(negedge clk) begin
        if (!s_cs && prev_cs) begin
            sl_cap = '0;
            sl_idx = 0;
            if (!sl_cpha) slave_drive();
        end else if (!s_cs && (s_sclk != prev_sclk)) begin
            if ((prev_sclk == sl_cpol) ^ sl_cpha) begin
                if (sl_lsb) sl_cap = (sl_cap >> 1) | (32'(s_mosi) << (sl_w - 1));
                else        sl_cap = (sl_cap << 1) | 32'(s_mosi);
            end else begin
                slave_drive();
            end
        end
        prev_sclk = s_sclk;
        prev_cs   = s_cs;
    end

    // Monitor: every done pops one expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && (done0 || done1)) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(done0) | (32'(done1) << 1), 32'h0);
            end else begin
                e = sbq.pop_front();
                check("done_inst", 32'(done1), 32'(e.inst));
                check("rx_data", done1 ? 32'(rx1) : 32'(rx0), e.rx);
                check("slave_capture", sl_cap & ((32'h1 << e.w) - 1), e.sl);
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
                check("sclk_idle", 32'(s_sclk), 32'(e.cpol));
            end
        end
    end

    task automatic push_exp(input int inst, input logic [31:0] rx, input logic [31:0] tx,
                            input int lat, input int t0, input logic pol);
        exp_t e;
        e.inst = inst; e.w = (inst != 0) ? 16 : 8;
        e.rx = rx & ((32'h1 << e.w) - 1);
        e.sl = tx & ((32'h1 << e.w) - 1);
        e.lat = lat; e.t0 = t0; e.cpol = pol;
        sbq.push_back(e);
    endtask

    task automatic send(input int inst, input logic [1:0] mode, input logic [31:0] tx,
                        input logic [31:0] rx, input int lat);
        @(negedge clk);
        sel = inst; sl_cpol = mode[1]; sl_cpha = mode[0];
        sl_w = (inst != 0) ? 16 : 8; sl_lsb = (inst != 0); sl_reply = rx;
        cpol = mode[1]; cpha = mode[0];
        if (inst != 0) begin tx1 = tx[15:0]; start1 = 1'b1; end
        else begin tx0 = tx[7:0]; start0 = 1'b1; end
        push_exp(inst, rx, tx, lat, cyc, mode[1]);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        check("busy_after_start", 32'((inst != 0) ? busy1 : busy0), 32'h1);
        check("cs_n_after_start", 32'((inst != 0) ? cs_n1 : cs_n0), 32'h0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            check("done_timeout", 32'(sbq.size()), 32'h0);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          inst;
        logic [1:0]  mode;
        logic [31:0] tx;
        logic [31:0] rx;
        int          lat;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int k;
        vecs[0] = '{0, SPI_MODE0, 32'hA5,   32'h3C,   73};
        vecs[1] = '{0, SPI_MODE3, 32'h81,   32'h7E,   73};
        vecs[2] = '{0, SPI_MODE1, 32'hC3,   32'h5A,   73};
        vecs[3] = '{0, SPI_MODE2, 32'h0F,   32'hF0,   73};
        vecs[4] = '{1, SPI_MODE0, 32'h1234, 32'hBEEF, 137};
        vecs[5] = '{1, SPI_MODE3, 32'h8001, 32'h7FFE, 137};
        vecs[6] = '{1, SPI_MODE1, 32'h00FF, 32'hA50F, 137};

        repeat (3) @(negedge clk);
        check("rst_sclk0", 32'(sclk0), 32'h0);
        check("rst_mosi0", 32'(mosi0), 32'h0);
        check("rst_cs_n0", 32'(cs_n0), 32'h1);
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_done0", 32'(done0), 32'h0);
        check("rst_rx0",   32'(rx0),   32'h0);
        check("rst_sclk1", 32'(sclk1), 32'h0);
        check("rst_cs_n1", 32'(cs_n1), 32'h1);
        check("rst_busy1", 32'(busy1), 32'h0);
        check("rst_rx1",   32'(rx1),   32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].inst, vecs[i].mode, vecs[i].tx, vecs[i].rx, vecs[i].lat);
            wait_idle();
        end

        // start and config changes mid-transfer are ignored
        send(0, SPI_MODE0, 32'h33, 32'hCC, 73);
        repeat (8) @(negedge clk);
        start0 = 1'b1; tx0 = 8'hFF; cpol = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle();
        repeat (100) @(negedge clk);

        // start held through done: back-to-back frames with one-cycle cs_n gap
        @(negedge clk);
        sel = 0; sl_cpol = 1'b0; sl_cpha = 1'b0; sl_w = 8; sl_lsb = 1'b0; sl_reply = 32'hC3;
        cpol = 1'b0; cpha = 1'b0; tx0 = 8'h96; start0 = 1'b1;
        k = cyc;
        push_exp(0, 32'hC3, 32'h96, 73, k, 1'b0);
        push_exp(0, 32'hC3, 32'h69, 73, k + int'(frame_cycles(8, 4)), 1'b0);
        @(negedge clk);
        tx0 = 8'h69;
        for (int i = 0; i < 200 && !done0; i++) @(negedge clk);
        check("b2b_first_done_cycle", 32'(cyc - k), 32'd73);
        check("b2b_gap_cs_n_high", 32'(cs_n0), 32'h1);
        @(negedge clk);
        start0 = 1'b0;
        check("b2b_gap_cs_n_low_again", 32'(cs_n0), 32'h0);
        check("b2b_busy_again", 32'(busy0), 32'h1);
        wait_idle();

        // reset mid-transfer aborts without done
        send(0, SPI_MODE0, 32'hF0, 32'h0F, 73);
        repeat (25) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n0), 32'h1);
        check("abort_sclk", 32'(sclk0), 32'h0);
        check("abort_busy", 32'(busy0), 32'h0);
        check("abort_rx",   32'(rx0),   32'h0);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (120) @(negedge clk);
        send(0, SPI_MODE0, 32'h5C, 32'hA3, 73);
        wait_idle();

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1; sl_quiet = 1'b1;
        send(0, SPI_MODE0, 32'h5A, 32'h5A, 73);
        wait_idle();
        loopback = 1'b0; sl_quiet = 1'b0;
`endif

        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
